load_store_unit: RTL

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit_if.sv | 35 +++
 rtl/load_store_unit.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/load_store_unit_if.sv
// Request/response handshake and data-memory port of the load/store unit.
// slave is the unit's view; master is the pipeline plus data-memory side.
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;

  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  logic [31:0] mem_access_addr;
  logic [31:0] mem_write_data;
  logic        mem_write_en;
  logic        mem_read;
  logic [31:0] mem_read_data;

  modport slave (
    input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    input  mem_read_data,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output mem_access_addr, mem_write_data, mem_write_en, mem_read
  );

  modport master (
    output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    output mem_read_data,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  mem_access_addr, mem_write_data, mem_write_en, mem_read
  );
endinterface

// File: rtl/load_store_unit.sv
// Single-issue load/store unit for a 256-word data memory. Sub-word stores
// are performed as a read-modify-write of the containing word.
module load_store_unit (
  input  logic            clk,
  input  logic            rst_n,
  load_store_unit_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    RMW_RD = 3'd2,
    WRITE  = 3'd3,
    DONE   = 3'd4
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  state_t      state;
  state_t      state_nxt;

  logic        accept;
  logic        req_err;

  logic [1:0]  size_p0;
  logic        unsigned_p0;
  logic        err_p0;
  logic [9:0]  addr_p0;
  logic [31:0] wdata_p0;
  logic [31:0] rdata_p1;

  function automatic logic access_error(input logic [1:0]  size,
                                        input logic [31:0] addr);
    logic bad;
    bad = (size == 2'b11)
        | ((size == SZ_HALF) & addr[0])
        | ((size == SZ_WORD) & (addr[1:0] != 2'b00))
        | (addr[31:10] != 22'd0);
    return bad;
  endfunction

  function automatic logic [31:0] lane_extend(input logic [31:0] word,
                                              input logic [1:0]  size,
                                              input logic        uns,
                                              input logic [1:0]  lane);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic [31:0]        r;
    b = $signed(word[{lane, 3'b000} +: 8]);
    h = $signed(word[{lane[1], 4'b0000} +: 16]);
    case (size)
      SZ_BYTE: r = uns ? {24'h0, b} : 32'(b);
      SZ_HALF: r = uns ? {16'h0, h} : 32'(h);
      default: r = word;
    endcase
    return r;
  endfunction

  // Replace the addressed byte/half of the memory word with the store data.
  function automatic logic [31:0] merge_lane(input logic [31:0] word,
                                             input logic [31:0] wdata,
                                             input logic [1:0]  size,
                                             input logic [1:0]  lane);
    logic [31:0] r;
    r = word;
    if (size == SZ_BYTE)
      r[{lane, 3'b000} +: 8] = wdata[7:0];
    else
      r[{lane[1], 4'b0000} +: 16] = wdata[15:0];
    return r;
  endfunction

  assign accept  = bus.req_valid && (state == IDLE);
  assign req_err = access_error(bus.req_size, bus.req_addr);

  // ---- state register ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // ---- next-state logic ----
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (req_err)                      state_nxt = DONE;
          else if (!bus.req_write)          state_nxt = LOAD;
          else if (bus.req_size == SZ_WORD) state_nxt = WRITE;
          else                              state_nxt = RMW_RD;
        end
      end
      LOAD:    state_nxt = DONE;
      RMW_RD:  state_nxt = WRITE;
      WRITE:   state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ---- outputs: strobes decode from state, buses come from held registers ----
  always_comb begin
    bus.req_ready       = (state == IDLE);
    bus.mem_read        = (state == LOAD) || (state == RMW_RD);
    bus.mem_write_en    = (state == WRITE);
    bus.resp_valid      = (state == DONE);
    bus.resp_err        = (state == DONE) && err_p0;
    bus.resp_rdata      = rdata_p1;
    bus.mem_access_addr = {24'h0, addr_p0[9:2]};
    bus.mem_write_data  = wdata_p0;
  end

  // ---- p0: request latch / merge register, p1: load result ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      size_p0     <= 2'b00;
      unsigned_p0 <= 1'b0;
      err_p0      <= 1'b0;
      addr_p0     <= '0;
      wdata_p0    <= '0;
      rdata_p1    <= '0;
    end else begin
      if (accept) begin
        size_p0     <= bus.req_size;
        unsigned_p0 <= bus.req_unsigned;
        err_p0      <= req_err;
        addr_p0     <= bus.req_addr[9:0];
        wdata_p0    <= bus.req_wdata;
        rdata_p1    <= '0;
      end
      if (state == LOAD)
        rdata_p1 <= lane_extend(bus.mem_read_data, size_p0, unsigned_p0, addr_p0[1:0]);
      if (state == RMW_RD)
        wdata_p0 <= merge_lane(bus.mem_read_data, wdata_p0, size_p0, addr_p0[1:0]);
    end
  end

endmodule
